// File: rtl/pixel_pair_packer.sv
// RGB888 -> RGB565 pixel pair packer feeding the video FIFO; tracks line/frame position and flags bad lines.
// Define PIXPACK_DITHER_EN to enable ordered 4x4 Bayer dithering ahead of truncation.
module pixel_pair_packer #(
  parameter int h = 1920,
  parameter int v = 1080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] in_rgb,
  input  logic        in_valid,
  input  logic        in_sol,
  input  logic        in_sof,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_odd,
  output logic        err_len
);

  localparam int XW = ($clog2(h + 1) < 2) ? 2 : $clog2(h + 1);
  localparam int YW = ($clog2(v) < 2) ? 2 : $clog2(v);
  localparam logic [XW-1:0] X_MAX  = XW'(h);
  localparam logic [YW-1:0] Y_LAST = YW'(v - 1);

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} state_t;

  state_t          state_r;
  logic [15:0]     even_r;
  logic [XW-1:0]   x_r;
  logic [YW-1:0]   y_r;
  logic            seen_sol_r;
  logic            accept_s;
  logic [XW-1:0]   x_cur_s;
  logic [YW-1:0]   y_cur_s;
  logic [15:0]     pix_s;

`ifdef PIXPACK_DITHER_EN
  function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] m;
    case ({row, col})
      4'd0:    m = 4'd0;
      4'd1:    m = 4'd8;
      4'd2:    m = 4'd2;
      4'd3:    m = 4'd10;
      4'd4:    m = 4'd12;
      4'd5:    m = 4'd4;
      4'd6:    m = 4'd14;
      4'd7:    m = 4'd6;
      4'd8:    m = 4'd3;
      4'd9:    m = 4'd11;
      4'd10:   m = 4'd1;
      4'd11:   m = 4'd9;
      4'd12:   m = 4'd15;
      4'd13:   m = 4'd7;
      4'd14:   m = 4'd13;
      4'd15:   m = 4'd5;
      default: m = 4'd0;
    endcase
    return m;
  endfunction

  // Add the dither offset with 8-bit saturation so bright pixels never wrap to dark.
  function automatic logic [8:0] sat_add(input logic [7:0] c, input logic [3:0] d);
    logic [8:0] s;
    s = {1'b0, c} + {5'b0_0000, d};
    return s[8] ? 9'h0FF : s;
  endfunction

  function automatic logic [15:0] to565(input logic [23:0] c, input logic [1:0] row,
                                        input logic [1:0] col);
    logic [3:0] m;
    logic [8:0] r;
    logic [8:0] g;
    logic [8:0] b;
    m = bayer(row, col);
    r = sat_add(c[23:16], {1'b0, m[3:1]});
    g = sat_add(c[15:8], {2'b00, m[3:2]});
    b = sat_add(c[7:0], {1'b0, m[3:1]});
    return {5'(r >> 3), 6'(g >> 2), 5'(b >> 3)};
  endfunction
`else
  function automatic logic [15:0] to565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction
`endif

  assign in_ready = ~out_valid | out_ready;
  assign accept_s = in_valid & in_ready;

  // Position of the pixel currently offered, used both to update counters and to index the matrix.
  always_comb begin
    x_cur_s = x_r;
    y_cur_s = y_r;
    if (in_sol) begin
      x_cur_s = XW'(1);
    end else if (x_r == X_MAX) begin
      x_cur_s = X_MAX;
    end else begin
      x_cur_s = x_r + XW'(1);
    end
    if (in_sof) begin
      y_cur_s = YW'(0);
    end else if (in_sol) begin
      if (y_r == Y_LAST) begin
        y_cur_s = YW'(0);
      end else begin
        y_cur_s = y_r + YW'(1);
      end
    end else begin
      y_cur_s = y_r;
    end
  end

  // Colour conversion of the offered pixel.
  always_comb begin
`ifdef PIXPACK_DITHER_EN
    pix_s = to565(in_rgb, y_cur_s[1:0], 2'(x_cur_s - XW'(1)));
`else
    pix_s = to565(in_rgb);
`endif
  end

  // Pairing FSM, output word register, position counters and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= EVEN;
      even_r     <= 16'h0000;
      x_r        <= XW'(0);
      y_r        <= YW'(0);
      seen_sol_r <= 1'b0;
      out_data   <= 32'h0000_0000;
      out_valid  <= 1'b0;
      err_odd    <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept_s) begin
        x_r <= x_cur_s;
        y_r <= y_cur_s;
        if (in_sol) begin
          seen_sol_r <= 1'b1;
          // The very first line start has no preceding line to measure.
          if (seen_sol_r && (x_r != X_MAX)) begin
            err_len <= 1'b1;
          end
        end
        case (state_r)
          EVEN: begin
            even_r  <= pix_s;
            state_r <= ODD;
          end
          ODD: begin
            out_valid <= 1'b1;
            if (in_sol) begin
              // Flush the orphaned even pixel; the new line's pixel becomes the next even half.
              out_data <= {16'h0000, even_r};
              even_r   <= pix_s;
              err_odd  <= 1'b1;
            end else begin
              out_data <= {pix_s, even_r};
              state_r  <= EVEN;
            end
          end
          default: state_r <= EVEN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_pair_packer.sv
// Self-checking bench for pixel_pair_packer: table-driven pair vectors, scoreboard of packed words,
// hand-written sequences for backpressure, malformed lines, async reset and (optionally) dithering.
module tb_pixel_pair_packer;

  localparam int H = 6;
  localparam int V = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] in_rgb = 24'h0;
  logic        in_valid = 1'b0;
  logic        in_sol = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        err_odd;
  logic        err_len;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_words = 1'b1;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [23:0] even;
    logic [23:0] odd;
    logic [31:0] word;
  } vec_t;
  vec_t tbl[4];

  pixel_pair_packer #(.h(H), .v(V)) dut (
    .clk(clk), .rst(rst), .in_rgb(in_rgb), .in_valid(in_valid), .in_sol(in_sol),
    .in_sof(in_sof), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err_odd(err_odd), .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Scoreboard: a word is taken at the next posedge when valid & ready at the negedge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word actual=%h required=none", out_data);
      end else begin
        logic [31:0] w;
        w = exp_q.pop_front();
        if (cmp_words) chk("word", out_data, w);
      end
    end
  end

  task automatic px(input logic [23:0] rgb, input logic sol, input logic sof);
    int n;
    in_rgb = rgb; in_sol = sol; in_sof = sof; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sol = 1'b0; in_sof = 1'b0;
  endtask

  task automatic pair(input logic [23:0] e, input logic [23:0] o, input logic sol,
                      input logic sof, input logic [31:0] w);
    exp_q.push_back(w);
    px(e, sol, sof);
    px(o, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{even: 24'hFFFFFF, odd: 24'h000000, word: 32'h0000_FFFF};
    tbl[1] = '{even: 24'h123456, odd: 24'hABCDEF, word: 32'hAE7D_11AA};
    tbl[2] = '{even: 24'h808080, odd: 24'h7F7F7F, word: 32'h7BEF_8410};
    tbl[3] = '{even: 24'h0000FF, odd: 24'hFF0000, word: 32'hF800_001F};
`ifdef PIXPACK_DITHER_EN
    cmp_words = 1'b0;
`endif

    // Reset state
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_err_odd", {31'b0, err_odd}, 32'd0);
    chk("rst_err_len", {31'b0, err_len}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

`ifndef PIXPACK_DITHER_EN
    // Basic pair, one-cycle latency, single-cycle valid
    pair(24'hFF0000, 24'h0000FF, 1'b1, 1'b1, 32'h001F_F800);
    chk("t2_valid", {31'b0, out_valid}, 32'd1);
    chk("t2_data", out_data, 32'h001F_F800);
    @(posedge clk); #1;
    chk("t2_valid_drop", {31'b0, out_valid}, 32'd0);

    for (int i = 0; i < 4; i++) pair(tbl[i].even, tbl[i].odd, 1'b0, 1'b0, tbl[i].word);
    drain();

    // Backpressure: held word stable, no pixel lost
    out_ready = 1'b0;
    pair(24'h123456, 24'hABCDEF, 1'b0, 1'b0, 32'hAE7D_11AA);
    in_rgb = 24'h808080; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_in_ready_low", {31'b0, in_ready}, 32'd0);
      chk("t3_data_held", out_data, 32'hAE7D_11AA);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_high", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(32'h7BEF_8410);
    px(24'h7F7F7F, 1'b0, 1'b0);
    drain();
`endif

    // Odd-length line followed by line start
    do_reset();
    pair(24'h010101, 24'h020202, 1'b1, 1'b1, 32'h0000_0000);
    px(24'h030303, 1'b0, 1'b0);
    exp_q.push_back(32'h0000_0000);
    px(24'h040404, 1'b1, 1'b0);
    chk("t4_err_odd", {31'b0, err_odd}, 32'd1);
    chk("t4_err_len_short", {31'b0, err_len}, 32'd1);
    drain();

    // Exact-length line then a short line of 4
    do_reset();
    chk("t4_err_odd_cleared", {31'b0, err_odd}, 32'd0);
    pair(24'h0, 24'h0, 1'b1, 1'b1, 32'h0);
    pair(24'h0, 24'h0, 1'b0, 1'b0, 32'h0);
    pair(24'h0, 24'h0, 1'b0, 1'b0, 32'h0);
    pair(24'h0, 24'h0, 1'b1, 1'b0, 32'h0);
    chk("t4_err_len_exact", {31'b0, err_len}, 32'd0);
    pair(24'h0, 24'h0, 1'b0, 1'b0, 32'h0);
    px(24'h0, 1'b1, 1'b0);
    chk("t4_err_len_four", {31'b0, err_len}, 32'd1);
    chk("t4_err_odd_four", {31'b0, err_odd}, 32'd0);

    // Asynchronous reset while ODD with a pending word
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back(32'h0000_8410);
    px(24'h808080, 1'b1, 1'b1);
    px(24'h7F7F7F, 1'b1, 1'b0);
    chk("t6_pre_valid", {31'b0, out_valid}, 32'd1);
`ifndef PIXPACK_DITHER_EN
    chk("t6_pre_data", out_data, 32'h0000_8410);
`endif
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_data", out_data, 32'h0);
    chk("t6_in_ready", {31'b0, in_ready}, 32'd1);
    chk("t6_err_odd", {31'b0, err_odd}, 32'd0);
    chk("t6_err_len", {31'b0, err_len}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
`ifndef PIXPACK_DITHER_EN
    pair(24'hFF0000, 24'h0000FF, 1'b0, 1'b0, 32'h001F_F800);
    drain();
`endif

`ifdef PIXPACK_DITHER_EN
    // Dither: matrix rows follow y, columns follow x, and saturation holds at 8 bits
    do_reset();
    cmp_words = 1'b1;
    pair(24'h040404, 24'h040404, 1'b1, 1'b1, 32'h0821_0020);
    pair(24'h0, 24'h0, 1'b0, 1'b0, 32'h0);
    pair(24'h0, 24'h0, 1'b0, 1'b0, 32'h0);
    pair(24'h040404, 24'h040404, 1'b1, 1'b0, 32'h0020_0821);
    pair(24'h0, 24'h0, 1'b0, 1'b0, 32'h0);
    pair(24'h0, 24'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) pair(24'h0, 24'h0, (i == 0), 1'b0, 32'h0);
    pair(24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 32'h0000_FFFF);
    pair(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 32'hFFFF_FFFF);
    pair(24'h0, 24'h0, 1'b0, 1'b0, 32'h0);
    drain();
    chk("dith_err_len", {31'b0, err_len}, 32'd0);
`endif

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
